// File: rtl/signext_pkg.sv
// Shared widths and enums for the immediate-extension arbiter slice.
package signext_pkg;

  localparam int DEF_IN_WIDTH  = 16;
  localparam int DEF_OUT_WIDTH = 32;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/signext.sv
// Sign-extends an IN_WIDTH immediate to OUT_WIDTH; purely combinational.
// Equal widths degenerate to a pass-through.
module signext #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic [IN_WIDTH-1:0]  imm,
  output logic [OUT_WIDTH-1:0] ext
);

  generate
    if (OUT_WIDTH > IN_WIDTH) begin : g_extend
      assign ext = {{(OUT_WIDTH-IN_WIDTH){imm[IN_WIDTH-1]}}, imm};
    end else begin : g_pass
      assign ext = imm;
    end
  endgenerate

endmodule

// File: rtl/signext_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, 0-cycle latency.
// last_grant moves only when the caller reports a completed transfer.
module rr_arb2
  import signext_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic gnt0,
  output logic gnt1
);

  req_id_t last_grant;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      // Contention: favour whoever did not win last time.
      if (last_grant == REQ1) gnt0 = 1'b1;
      else                    gnt1 = 1'b1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= REQ1;
    end else if (update) begin
      last_grant <= gnt1 ? REQ1 : REQ0;
    end
  end

endmodule

// File: rtl/signext_arbiter.sv
// Round-robin shares one immediate extender between two requesters; 1-cycle latency.
// Single output slot: requesters see ready only when the slot is empty or draining.
module signext_arbiter
  import signext_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [IN_WIDTH-1:0]  req0_imm,
  input  logic                 req0_zext,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [IN_WIDTH-1:0]  req1_imm,
  input  logic                 req1_zext,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [OUT_WIDTH-1:0] rsp_data,
  output logic                 rsp_id
);

  slot_state_t          state_q, state_d;
  req_id_t              rsp_id_q;
  logic                 gnt0, gnt1;
  logic                 can_accept;
  logic                 xfer;
  logic [IN_WIDTH-1:0]  sel_imm;
  logic                 sel_zext;
  logic [OUT_WIDTH-1:0] sext_val;
  logic [OUT_WIDTH-1:0] zext_val;
  logic [OUT_WIDTH-1:0] ext_val;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0_valid),
    .req1   (req1_valid),
    .update (xfer),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  assign rsp_valid  = (state_q == FULL);
  assign rsp_id     = rsp_id_q;
  assign can_accept = !rsp_valid || rsp_ready;

  // Readies are held low in reset so nothing transfers in a reset cycle.
  assign req0_ready = gnt0 && can_accept && !reset;
  assign req1_ready = gnt1 && can_accept && !reset;
  assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign sel_imm  = gnt1 ? req1_imm  : req0_imm;
  assign sel_zext = gnt1 ? req1_zext : req0_zext;

  signext #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_signext (
    .imm (sel_imm),
    .ext (sext_val)
  );

  generate
    if (OUT_WIDTH > IN_WIDTH) begin : g_zext
      assign zext_val = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, sel_imm};
    end else begin : g_zpass
      assign zext_val = sel_imm;
    end
  endgenerate

  assign ext_val = sel_zext ? zext_val : sext_val;

  always_comb begin
    state_d = state_q;
    if (xfer)           state_d = FULL;
    else if (rsp_ready) state_d = EMPTY;
  end

  // Payload holds its last value after a drain; only a transfer rewrites it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      rsp_data <= '0;
      rsp_id_q <= REQ0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        rsp_data <= ext_val;
        rsp_id_q <= gnt1 ? REQ1 : REQ0;
      end
    end
  end

endmodule

// File: tb/tb_signext_arbiter.sv
// Self-checking bench: directed vector table, hand-written reset cases, random traffic vs model.
module tb_signext_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_zext;
  logic        req1_valid, req1_ready, req1_zext;
  logic [15:0] req0_imm, req1_imm;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: slot contents and which requester wins the next tie.
  logic        m_vld;
  logic [31:0] m_data;
  logic        m_id;
  logic        m_pref;
  logic        e_r0, e_r1;
  logic        act_r0, act_r1;

  signext_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_imm   (req0_imm),
    .req0_zext  (req0_zext),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_imm   (req1_imm),
    .req1_zext  (req1_zext),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ext_ref(input logic [15:0] imm, input logic z);
    if (z) return {16'h0000, imm};
    return 32'($signed(imm));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_vld  = 1'b0;
    m_data = 32'h0;
    m_id   = 1'b0;
    m_pref = 1'b0;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset      = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_imm   = 16'hA5A5;
      req1_imm   = 16'h5A5A;
      rsp_ready  = 1'b0;
      #1;
      check("reset_req0_ready", 32'(req0_ready), 32'd0);
      check("reset_req1_ready", 32'(req1_ready), 32'd0);
      @(posedge clk);
      #1;
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    check("reset_rsp_data", rsp_data, 32'h0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    model_reset();
  endtask

  // One clock of stimulus: readies checked before the edge, slot checked after it.
  task automatic step(input logic v0, input logic [15:0] i0, input logic z0,
                      input logic v1, input logic [15:0] i1, input logic z1,
                      input logic rr);
    logic can, w1;
    @(negedge clk);
    reset      = 1'b0;
    req0_valid = v0; req0_imm = i0; req0_zext = z0;
    req1_valid = v1; req1_imm = i1; req1_zext = z1;
    rsp_ready  = rr;
    #1;
    can  = !m_vld || rr;
    w1   = (v0 && v1) ? m_pref : v1;
    e_r0 = can && v0 && !w1;
    e_r1 = can && v1 && w1;
    act_r0 = req0_ready;
    act_r1 = req1_ready;
    check("req0_ready", 32'(act_r0), 32'(e_r0));
    check("req1_ready", 32'(act_r1), 32'(e_r1));
    @(posedge clk);
    #1;
    if (e_r0 || e_r1) begin
      m_vld  = 1'b1;
      m_id   = w1;
      m_data = w1 ? ext_ref(i1, z1) : ext_ref(i0, z0);
      m_pref = !w1;
    end else if (rr) begin
      m_vld = 1'b0;
    end
    check("rsp_valid", 32'(rsp_valid), 32'(m_vld));
    check("rsp_data", rsp_data, m_data);
    check("rsp_id", 32'(rsp_id), 32'(m_id));
  endtask

  typedef struct {
    logic        v0;
    logic [15:0] i0;
    logic        z0;
    logic        v1;
    logic [15:0] i1;
    logic        z1;
    logic        rr;
    logic        r0;
    logic        r1;
    logic        vld;
    logic [31:0] data;
    logic        id;
  } vec_t;

  vec_t tbl [17];

  logic        pv0, pz0, pv1, pz1;
  logic [15:0] pi0, pi1;

  initial begin
    // Starting from reset; expectations derived by hand.
    tbl[0]  = '{1'b1, 16'h8001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF8001, 1'b0};
    tbl[1]  = '{1'b1, 16'h8001, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00008001, 1'b0};
    tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00008001, 1'b0};
    tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00001234, 1'b1};
    for (int k = 4; k < 8; k++)
      tbl[k] = '{1'b1, 16'h0042, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00001234, 1'b1};
    tbl[8]  = '{1'b1, 16'h0042, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00000042, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1};
    for (int k = 10; k < 16; k++) begin
      if (k % 2 == 0)
        tbl[k] = '{1'b1, 16'h7FFF, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00007FFF, 1'b0};
      else
        tbl[k] = '{1'b1, 16'h7FFF, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1};
    end
    tbl[16] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1};

    reset = 1'b1;
    req0_valid = 1'b0; req0_imm = 16'h0; req0_zext = 1'b0;
    req1_valid = 1'b0; req1_imm = 16'h0; req1_zext = 1'b0;
    rsp_ready  = 1'b0;
    model_reset();

    do_reset(3);

    for (int k = 0; k < 17; k++) begin
      step(tbl[k].v0, tbl[k].i0, tbl[k].z0, tbl[k].v1, tbl[k].i1, tbl[k].z1, tbl[k].rr);
      check($sformatf("vec%0d_req0_ready", k), 32'(act_r0), 32'(tbl[k].r0));
      check($sformatf("vec%0d_req1_ready", k), 32'(act_r1), 32'(tbl[k].r1));
      check($sformatf("vec%0d_rsp_valid", k), 32'(rsp_valid), 32'(tbl[k].vld));
      check($sformatf("vec%0d_rsp_data", k), rsp_data, tbl[k].data);
      check($sformatf("vec%0d_rsp_id", k), 32'(rsp_id), 32'(tbl[k].id));
    end

    // Reset while stalled: pending result discarded, requester 0 preferred again.
    step(1'b1, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("stall_rsp_data", rsp_data, 32'h00005555);
    do_reset(1);
    step(1'b1, 16'h0011, 1'b0, 1'b1, 16'h0022, 1'b0, 1'b1);
    check("post_reset_req0_first", 32'(act_r0), 32'd1);
    check("post_reset_rsp_id", 32'(rsp_id), 32'd0);
    check("post_reset_rsp_data", rsp_data, 32'h00000011);

    // Random traffic; requesters hold their request until accepted.
    pv0 = 1'b0; pv1 = 1'b0;
    pi0 = 16'h0; pi1 = 16'h0; pz0 = 1'b0; pz1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pv0) begin
        pv0 = 1'($urandom_range(0, 1));
        pi0 = 16'($urandom);
        pz0 = 1'($urandom_range(0, 1));
      end
      if (!pv1) begin
        pv1 = 1'($urandom_range(0, 1));
        pi1 = 16'($urandom);
        pz1 = 1'($urandom_range(0, 1));
      end
      step(pv0, pi0, pz0, pv1, pi1, pz1, ($urandom_range(0, 3) != 0));
      if (e_r0) pv0 = 1'b0;
      if (e_r1) pv1 = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
